data_memory_ctrl: RTL and testbench

- Parametrised, byte-addressed, little-endian data memory for the pipeline's MEM stage.
- Adds to the single-cycle data memory:
  - a valid/ready request/response handshake;
  - configurable read latency;
  - response backpressure;
  - access sizes up to a full data word;
  - explicit sign/zero extension control;
  - out-of-range/illegal-size error reporting.
- One access outstanding at a time, so the pipeline stalls on req_ready.

---
 rtl/data_memory_ctrl.sv | 129 ++++++++++++
 tb/tb_data_memory_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
`timescale 1ns/1ps
// Byte-addressed little-endian data memory with valid/ready request/response handshake.
// Response after RD_LATENCY cycles; one access in flight, req_ready low until the response is taken.
module data_memory_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_BYTES = 256,
  parameter int DATA_BYTES  = 2,
  parameter int RD_LATENCY  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*DATA_BYTES-1:0] rsp_rdata,
  output logic                    rsp_error
);

  localparam int W      = 8 * DATA_BYTES;
  localparam int MEM_AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [2:0]            LAT_M1 = 3'(RD_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0]   ONE    = (ADDR_WIDTH+1)'(1);

  logic [1:0]          state;
  logic [2:0]          cnt;
  logic [7:0]          mem [DEPTH_BYTES];

  logic                accept;
  logic [31:0]         nb;
  logic [ADDR_WIDTH:0] last_addr;
  logic                illegal;
  logic [MEM_AW-1:0]   byte_idx [DATA_BYTES];
  logic [W-1:0]        load_data;
  logic                sign_bit;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid & req_ready;

  always_comb begin
    nb = 32'd0;
    case (req_size)
      2'b00:   nb = 32'd1;
      2'b01:   nb = 32'd2;
      2'b10:   nb = DATA_BYTES;
      default: nb = 32'd0;
    endcase
  end

  // Extra top bit keeps the end-address check from wrapping near the top of the address space.
  assign last_addr = {1'b0, req_addr} + (ADDR_WIDTH+1)'(nb) - ONE;
  assign illegal   = (req_size == 2'b11) || (nb > DATA_BYTES) ||
                     (32'(last_addr) >= DEPTH_BYTES);

  always_comb begin
    for (int i = 0; i < DATA_BYTES; i++) begin
      byte_idx[i] = MEM_AW'({1'b0, req_addr} + (ADDR_WIDTH+1)'(i));
    end
  end

  always_comb begin
    load_data = '0;
    sign_bit  = 1'b0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (i < nb) begin
        load_data[8*i +: 8] = mem[byte_idx[i]];
        sign_bit            = mem[byte_idx[i]][7];
      end
    end
    // Bytes above the access width replicate the MSB of the top byte read.
    if (req_signed) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (i >= nb) load_data[8*i +: 8] = {8{sign_bit}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && req_write && !illegal) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (i < nb) mem[byte_idx[i]] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rsp_error <= illegal;
            rsp_rdata <= (illegal || req_write) ? '0 : load_data;
            if (RD_LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
`timescale 1ns/1ps
// Directed bench: three controller instances (16-bit/lat1, 32-bit/lat3, 8-bit/lat2) share one request bus.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;
  logic [2:0]  req_ready;
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_error;
  logic [15:0] rdata0;
  logic [31:0] rdata1;
  logic [7:0]  rdata2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.ADDR_WIDTH(16), .DEPTH_BYTES(256), .DATA_BYTES(2), .RD_LATENCY(1)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata[15:0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
    .rsp_rdata(rdata0), .rsp_error(rsp_error[0])
  );

  data_memory_ctrl #(.ADDR_WIDTH(16), .DEPTH_BYTES(256), .DATA_BYTES(4), .RD_LATENCY(3)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
    .rsp_rdata(rdata1), .rsp_error(rsp_error[1])
  );

  data_memory_ctrl #(.ADDR_WIDTH(16), .DEPTH_BYTES(256), .DATA_BYTES(1), .RD_LATENCY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata[7:0]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready),
    .rsp_rdata(rdata2), .rsp_error(rsp_error[2])
  );

  function automatic logic [31:0] get_rd(input int sel);
    case (sel)
      0:       return {16'h0, rdata0};
      1:       return rdata1;
      default: return {24'h0, rdata2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction on instance sel; hold = cycles rsp_ready is held low once rsp_valid is up.
  task automatic access(input int sel, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [15:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int hold, input string tag);
    int lat;
    int w;
    @(negedge clk);
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 3'b000;
    req_valid[sel] = 1'b1;
    rsp_ready  = (hold == 0);
    w = 0;
    while (!req_ready[sel] && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready[sel]) begin
      check({tag, "_rdy_timeout"}, 32'd0, 32'd1);
      req_valid = 3'b000;
      rsp_ready = 1'b1;
      return;
    end
    @(posedge clk);
    #1 req_valid = 3'b000;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[sel] && lat < 10);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, get_rd(sel), exp_rd);
    check({tag, "_err"}, rsp_error[sel], exp_err);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_vld"}, rsp_valid[sel], 1'b1);
      check({tag, "_hold_rdata"}, get_rd(sel), exp_rd);
      check({tag, "_hold_rdy"}, req_ready[sel], 1'b0);
    end
    rsp_ready = 1'b1;
    check({tag, "_resp_rdy"}, req_ready[sel], 1'b0);
    @(negedge clk);
    check({tag, "_done_vld"}, rsp_valid[sel], 1'b0);
    check({tag, "_done_rdy"}, req_ready[sel], 1'b1);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 3'b000;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 16'h0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 3'b111);
    check("rst_rsp_valid", rsp_valid, 3'b000);
    check("rst_rdata0", rdata0, 16'h0);
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_error", rsp_error, 3'b000);
    rst_n = 1'b1;

    // 16-bit, latency 1: little-endian, extension, errors
    access(0, 1, 2'b01, 0, 16'h0010, 32'h0000A55A, 32'h0, 0, 1, 0, "u0_st_half");
    access(0, 0, 2'b01, 0, 16'h0010, 32'hDEADBEEF, 32'h0000A55A, 0, 1, 0, "u0_ld_half");
    access(0, 0, 2'b00, 0, 16'h0010, 32'h0, 32'h0000005A, 0, 1, 0, "u0_ld_b10");
    access(0, 0, 2'b00, 0, 16'h0011, 32'h0, 32'h000000A5, 0, 1, 0, "u0_ld_b11");
    access(0, 0, 2'b00, 1, 16'h0011, 32'h0, 32'h0000FFA5, 0, 1, 0, "u0_ld_b11_s");
    access(0, 1, 2'b00, 0, 16'h0005, 32'h00000080, 32'h0, 0, 1, 0, "u0_st_b80");
    access(0, 0, 2'b00, 1, 16'h0005, 32'h0, 32'h0000FF80, 0, 1, 0, "u0_ld_b5_s");
    access(0, 0, 2'b00, 0, 16'h0005, 32'h0, 32'h00000080, 0, 1, 0, "u0_ld_b5_u");
    access(0, 0, 2'b10, 1, 16'h0010, 32'h0, 32'h0000A55A, 0, 1, 0, "u0_ld_word_s");
    access(0, 1, 2'b01, 0, 16'h00FE, 32'h0000BEEF, 32'h0, 0, 1, 0, "u0_st_fe");
    access(0, 0, 2'b01, 0, 16'h00FE, 32'h0, 32'h0000BEEF, 0, 1, 0, "u0_ld_fe");
    access(0, 1, 2'b01, 0, 16'h00FF, 32'h00001234, 32'h0, 1, 1, 0, "u0_st_ff_err");
    access(0, 0, 2'b00, 0, 16'h00FF, 32'h0, 32'h000000BE, 0, 1, 0, "u0_ld_ff");
    access(0, 1, 2'b01, 0, 16'hFFFF, 32'h00001234, 32'h0, 1, 1, 0, "u0_st_wrap_err");
    access(0, 0, 2'b11, 0, 16'h0010, 32'h0, 32'h0, 1, 1, 0, "u0_ld_sz3");
    access(0, 1, 2'b11, 0, 16'h0010, 32'h00007777, 32'h0, 1, 1, 0, "u0_st_sz3");
    access(0, 0, 2'b01, 0, 16'h0010, 32'h0, 32'h0000A55A, 0, 1, 0, "u0_ld_after_sz3");

    // 32-bit, latency 3: half sign extension, misaligned word, backpressure
    access(1, 1, 2'b01, 0, 16'h0040, 32'h00008001, 32'h0, 0, 3, 0, "u1_st_half");
    access(1, 0, 2'b01, 1, 16'h0040, 32'h0, 32'hFFFF8001, 0, 3, 0, "u1_ld_half_s");
    access(1, 0, 2'b01, 0, 16'h0040, 32'h0, 32'h00008001, 0, 3, 0, "u1_ld_half_u");
    access(1, 0, 2'b00, 1, 16'h0041, 32'h0, 32'hFFFFFF80, 0, 3, 0, "u1_ld_b41_s");
    access(1, 1, 2'b10, 0, 16'h0021, 32'h11223344, 32'h0, 0, 3, 0, "u1_st_word");
    access(1, 0, 2'b00, 0, 16'h0021, 32'h0, 32'h00000044, 0, 3, 0, "u1_ld_b21");
    access(1, 0, 2'b00, 0, 16'h0022, 32'h0, 32'h00000033, 0, 3, 0, "u1_ld_b22");
    access(1, 0, 2'b00, 0, 16'h0023, 32'h0, 32'h00000022, 0, 3, 0, "u1_ld_b23");
    access(1, 0, 2'b00, 0, 16'h0024, 32'h0, 32'h00000011, 0, 3, 0, "u1_ld_b24");
    access(1, 0, 2'b10, 0, 16'h0021, 32'h0, 32'h11223344, 0, 3, 4, "u1_ld_word_hold");
    access(1, 1, 2'b10, 0, 16'h00FD, 32'hCAFEF00D, 32'h0, 1, 3, 0, "u1_st_word_err");

    // 8-bit, latency 2: half is wider than the data word
    access(2, 1, 2'b01, 0, 16'h0000, 32'h000000AA, 32'h0, 1, 2, 0, "u2_st_half_err");
    access(2, 1, 2'b10, 0, 16'h0007, 32'h00000080, 32'h0, 0, 2, 0, "u2_st_word");
    access(2, 0, 2'b00, 1, 16'h0007, 32'h0, 32'h00000080, 0, 2, 0, "u2_ld_b_s");
    access(2, 0, 2'b01, 0, 16'h0007, 32'h0, 32'h0, 1, 2, 0, "u2_ld_half_err");

    // reset while a store is waiting out its latency
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 16'h0003; req_wdata = 32'h0000007E;
    req_valid = 3'b010; rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 3'b000;
    check("rstw_rdy_in_wait", req_ready[1], 1'b0);
    #2 rst_n = 1'b0;
    #1 check("rstw_rdy_async", req_ready[1], 1'b1);
    check("rstw_vld_async", rsp_valid[1], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1, 0, 2'b00, 0, 16'h0003, 32'h0, 32'h0000007E, 0, 3, 0, "rstw_ld_b3");

    // reset while a load response is pending
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b00; req_addr = 16'h0024;
    req_valid = 3'b010; rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 3'b000;
    repeat (3) @(negedge clk);
    check("rstr_vld_before", rsp_valid[1], 1'b1);
    check("rstr_rdata_before", rdata1, 32'h00000011);
    #2 rst_n = 1'b0;
    #1 check("rstr_vld_async", rsp_valid[1], 1'b0);
    check("rstr_rdata_async", rdata1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rstr_rdy_after", req_ready[1], 1'b1);
    check("rstr_vld_after", rsp_valid[1], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
